masc_exec_sched: RTL and testbench

//  Round-robin scheduler sharing one __masc__execute unit between NUM_REQ requesters.

---
 rtl/masc_exec_sched_pkg.sv | 19 +
 rtl/masc_exec_sched_if.sv | 53 +++++
 rtl/masc_exec_sched_rsp_fifo.sv | 79 +++++++
 rtl/masc_exec_sched.sv | 155 +++++++++++++++
 tb/tb_masc_exec_sched.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/masc_exec_sched_pkg.sv
// Shared types and widths for the masc execute-unit scheduler.
// The round-robin wrap helper is used by the arbiter pointer update.
package masc_exec_pkg;

  localparam int INSTR_W   = 32;
  localparam int DATA_W    = 32;
  localparam int BS_W      = 8;
  localparam int EXU_OUT_W = 33;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sched_state_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/masc_exec_sched_if.sv
// Bundle of requester, execute-unit, response and flush signals of the scheduler.
// master is the scheduler side, slave is the surrounding environment.
interface masc_exec_sched_if #(
  parameter int NUM_REQ = 2
) ();
  import masc_exec_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*INSTR_W-1:0] req_instr;
  logic [NUM_REQ*DATA_W-1:0]  req_rs1;
  logic [NUM_REQ*DATA_W-1:0]  req_rs2;
  logic [NUM_REQ*BS_W-1:0]    req_bs;

  logic [INSTR_W-1:0]         exu_instruction;
  logic [DATA_W-1:0]          exu_rs1;
  logic [DATA_W-1:0]          exu_rs2;
  logic [BS_W-1:0]            exu_bs;
  logic                       exu_valid;
  logic [EXU_OUT_W-1:0]       exu_out;

  logic [NUM_REQ-1:0]         rsp_valid;
  logic [NUM_REQ-1:0]         rsp_ready;
  logic [NUM_REQ*DATA_W-1:0]  rsp_data;
  logic [NUM_REQ-1:0]         rsp_ok;

  logic                       flush_req;
  logic                       flush_done;
  logic                       busy;

  modport master (
    input  req_valid, req_instr, req_rs1, req_rs2, req_bs,
    output req_ready,
    output exu_instruction, exu_rs1, exu_rs2, exu_bs, exu_valid,
    input  exu_out,
    output rsp_valid, rsp_data, rsp_ok,
    input  rsp_ready,
    input  flush_req,
    output flush_done, busy
  );

  modport slave (
    output req_valid, req_instr, req_rs1, req_rs2, req_bs,
    input  req_ready,
    input  exu_instruction, exu_rs1, exu_rs2, exu_bs, exu_valid,
    output exu_out,
    input  rsp_valid, rsp_data, rsp_ok,
    output rsp_ready,
    output flush_req,
    input  flush_done, busy
  );

endinterface

// File: rtl/masc_exec_sched_rsp_fifo.sv
// Per-requester response FIFO holding {result-valid flag, data}, plus an
// overflow checker that flags a push into a full FIFO.
module masc_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign empty     = (count_q == {CNT_W{1'b0}});
  assign full      = (count_q == CNT_W'(DEPTH));
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

endmodule

module masc_rsp_fifo_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic full
);

  property p_no_overflow;
    @(posedge clk) disable iff (reset) !(push && full);
  endproperty

  a_no_overflow: assert property (p_no_overflow);

endmodule

// File: rtl/masc_exec_sched.sv
// Round-robin, credit-gated scheduler sharing one execute unit among NUM_REQ
// requesters, with in-order per-requester result FIFOs and a drain handshake.
module masc_exec_sched
  import masc_exec_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int EXEC_LAT  = 1,
  parameter int RSP_DEPTH = 2
) (
  input logic                clk,
  input logic                reset,
  masc_exec_sched_if.master  bus
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CRED_W = $clog2(RSP_DEPTH + 1);

  sched_state_e       state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [EXEC_LAT-1:0] tag_v_q;
  logic [IDX_W-1:0]   tag_idx_q [EXEC_LAT];

  logic [NUM_REQ-1:0] eligible_s, grant_s, pop_s, push_s, empty_s, full_s;
  logic [IDX_W-1:0]   winner_s, arb_idx_s;
  logic               any_grant_s, found_s, arb_hit_s, last_v_s, flush_done_s;

  // Round-robin pick: first eligible requester at or after the pointer.
  always_comb begin
    grant_s   = {NUM_REQ{1'b0}};
    winner_s  = {IDX_W{1'b0}};
    found_s   = 1'b0;
    arb_idx_s = {IDX_W{1'b0}};
    arb_hit_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx_s          = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      arb_hit_s          = !found_s && eligible_s[arb_idx_s];
      grant_s[arb_idx_s] = grant_s[arb_idx_s] | arb_hit_s;
      winner_s           = arb_hit_s ? arb_idx_s : winner_s;
      found_s            = found_s | arb_hit_s;
    end
  end

  assign any_grant_s = |grant_s;
  assign ptr_d       = any_grant_s ? IDX_W'(rr_next(int'(winner_s), NUM_REQ)) : ptr_q;
  assign last_v_s    = tag_v_q[EXEC_LAT-1];

  assign bus.req_ready       = grant_s;
  assign bus.exu_valid       = any_grant_s;
  assign bus.exu_instruction = any_grant_s ? bus.req_instr[winner_s*INSTR_W +: INSTR_W] : {INSTR_W{1'b0}};
  assign bus.exu_rs1         = any_grant_s ? bus.req_rs1[winner_s*DATA_W +: DATA_W] : {DATA_W{1'b0}};
  assign bus.exu_rs2         = any_grant_s ? bus.req_rs2[winner_s*DATA_W +: DATA_W] : {DATA_W{1'b0}};
  assign bus.exu_bs          = any_grant_s ? bus.req_bs[winner_s*BS_W +: BS_W] : {BS_W{1'b0}};

  assign bus.flush_done = flush_done_s;
  assign bus.busy       = (|tag_v_q) | (|(~empty_s));

  // Drain FSM: DRAIN blocks issue until the tag pipe is empty; FIFOs are kept.
  always_comb begin
    state_d      = state_q;
    flush_done_s = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.flush_req) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (tag_v_q == {EXEC_LAT{1'b0}}) begin
          state_d      = RUN;
          flush_done_s = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, arbitration pointer and tag pipe; a reset drops every in-flight tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      ptr_q   <= {IDX_W{1'b0}};
      tag_v_q <= {EXEC_LAT{1'b0}};
      for (int s = 0; s < EXEC_LAT; s++) begin
        tag_idx_q[s] <= {IDX_W{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      tag_v_q[0]   <= any_grant_s;
      tag_idx_q[0] <= winner_s;
      for (int s = 1; s < EXEC_LAT; s++) begin
        tag_v_q[s]   <= tag_v_q[s-1];
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    logic [CRED_W-1:0]    credit_q, credit_d;
    logic [EXU_OUT_W-1:0] dout_s;

    assign eligible_s[g] = bus.req_valid[g] && (credit_q != {CRED_W{1'b0}}) &&
                           (state_q == RUN) && !bus.flush_req;
    assign push_s[g]     = last_v_s && (tag_idx_q[EXEC_LAT-1] == IDX_W'(g));
    assign pop_s[g]      = bus.rsp_ready[g] && !empty_s[g];

    assign bus.rsp_valid[g]                  = !empty_s[g];
    assign bus.rsp_data[g*DATA_W +: DATA_W]  = dout_s[DATA_W-1:0];
    assign bus.rsp_ok[g]                     = dout_s[DATA_W];

    // A credit is taken at issue and returned when the response is consumed.
    always_comb begin
      credit_d = credit_q;
      case ({grant_s[g], pop_s[g]})
        2'b10:   credit_d = credit_q - CRED_W'(1);
        2'b01:   credit_d = credit_q + CRED_W'(1);
        default: credit_d = credit_q;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        credit_q <= CRED_W'(RSP_DEPTH);
      end else begin
        credit_q <= credit_d;
      end
    end

    masc_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .W     (EXU_OUT_W)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s[g]),
      .din   (bus.exu_out),
      .pop   (pop_s[g]),
      .dout  (dout_s),
      .empty (empty_s[g]),
      .full  (full_s[g])
    );

    masc_rsp_fifo_chk u_chk (
      .clk   (clk),
      .reset (reset),
      .push  (push_s[g]),
      .full  (full_s[g])
    );
  end

endmodule

// File: tb/tb_masc_exec_sched.sv
// Self-checking bench: execute model out = {1, rs1+rs2} one edge after issue;
// a negedge scoreboard matches every consumed response against issue order.
module tb_masc_exec_sched;
  import masc_exec_pkg::*;

  localparam int NUM_REQ   = 2;
  localparam int EXEC_LAT  = 1;
  localparam int RSP_DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  masc_exec_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

  masc_exec_sched #(
    .NUM_REQ   (NUM_REQ),
    .EXEC_LAT  (EXEC_LAT),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [32:0] exu_model_q;
  always @(posedge clk) begin
    exu_model_q <= bus.exu_valid ? {1'b1, bus.exu_rs1 + bus.exu_rs2} : 33'h1_BAD0_BAD0;
  end
  assign bus.exu_out = exu_model_q;

  int n_checks = 0;
  int n_fail   = 0;
  int rr_exp   = 0;
  logic [32:0] sb_q [NUM_REQ][$];
  logic [32:0] mon_exp, mon_got;

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) sb_q[i].delete();
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_ready[i])
          sb_q[i].push_back({1'b1, bus.req_rs1[32*i +: 32] + bus.req_rs2[32*i +: 32]});
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          n_checks++;
          mon_got = {bus.rsp_ok[i], bus.rsp_data[32*i +: 32]};
          if (sb_q[i].size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_req%0d: got %h, expected no response", i, mon_got);
          end else begin
            mon_exp = sb_q[i].pop_front();
            if (mon_got !== mon_exp) begin
              n_fail++;
              $display("FAIL scoreboard_req%0d: got %h, expected %h", i, mon_got, mon_exp);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] ins,
                         input logic [31:0] r1, input logic [31:0] r2);
    bus.req_valid[i]          = v;
    bus.req_instr[32*i +: 32] = ins;
    bus.req_rs1[32*i +: 32]   = r1;
    bus.req_rs2[32*i +: 32]   = r2;
    bus.req_bs[8*i +: 8]      = ins[7:0];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b, expected 00", bus.req_ready); end
    n_checks++;
    if ({bus.exu_valid, bus.exu_instruction, bus.exu_rs1, bus.exu_rs2, bus.exu_bs} !== 105'd0) begin
      n_fail++; $display("FAIL reset_exu: got valid=%b instr=%h, expected all zero", bus.exu_valid, bus.exu_instruction);
    end
    n_checks++;
    if ({bus.rsp_valid, bus.flush_done, bus.busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_status: got rsp_valid=%b done=%b busy=%b, expected 0", bus.rsp_valid, bus.flush_done, bus.busy);
    end
    reset  = 1'b0;
    rr_exp = 0;
  endtask

  task automatic test_single();
    tick();
    set_req(0, 1'b1, 32'd3, 32'd5, 32'd7);
    bus.rsp_ready = 2'b11;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b, expected 01", bus.req_ready); end
    n_checks++;
    if ({bus.exu_valid, bus.exu_instruction, bus.exu_rs1, bus.exu_rs2, bus.exu_bs} !==
        {1'b1, 32'd3, 32'd5, 32'd7, 8'd3}) begin
      n_fail++; $display("FAIL single_exu: got instr=%h rs1=%h rs2=%h, expected 3/5/7", bus.exu_instruction, bus.exu_rs1, bus.exu_rs2);
    end
    rr_exp = 1;
    tick();
    set_req(0, 1'b0, 32'd0, 32'd0, 32'd0);
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.busy} !== 3'b001) begin
      n_fail++; $display("FAIL single_nobypass: got rsp_valid=%b busy=%b, expected 00/1", bus.rsp_valid, bus.busy);
    end
    tick();
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_ok[0], bus.rsp_data[31:0]} !== {2'b01, 1'b1, 32'h0000_000C}) begin
      n_fail++; $display("FAIL single_rsp: got valid=%b ok=%b data=%h, expected 01/1/0000000c", bus.rsp_valid, bus.rsp_ok[0], bus.rsp_data[31:0]);
    end
    tick();
    n_checks++;
    if ({bus.rsp_valid, bus.busy} !== 3'b000) begin
      n_fail++; $display("FAIL single_idle: got rsp_valid=%b busy=%b, expected 0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_fairness();
    int g0 = 0;
    int g1 = 0;
    logic [1:0] exp;
    bus.rsp_ready = 2'b11;
    tick();
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1'b1, $urandom, $urandom, $urandom);
      set_req(1, 1'b1, $urandom, $urandom, $urandom);
      #1;
      exp = (rr_exp == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if (bus.req_ready !== exp) begin n_fail++; $display("FAIL fairness_cycle%0d: got %b, expected %b", c, bus.req_ready, exp); end
      if (exp[0]) g0++; else g1++;
      rr_exp = 1 - rr_exp;
      tick();
    end
    set_req(0, 1'b0, 32'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if (g0 != 4 || g1 != 4) begin n_fail++; $display("FAIL fairness_count: got %0d/%0d, expected 4/4", g0, g1); end
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    logic [1:0] exp;
    bus.rsp_ready = 2'b10;
    for (int c = 0; c < 6; c++) begin
      set_req(0, 1'b1, $urandom, $urandom, $urandom);
      #1;
      exp = (c < 2) ? 2'b01 : 2'b00;
      n_checks++;
      if (bus.req_ready !== exp) begin n_fail++; $display("FAIL backpressure_cycle%0d: got %b, expected %b", c, bus.req_ready, exp); end
      if (exp[0]) rr_exp = 1;
      tick();
    end
    bus.rsp_ready[0] = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL backpressure_popcycle: got %b, expected 00", bus.req_ready); end
    tick();
    bus.rsp_ready[0] = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL backpressure_refill: got %b, expected 01", bus.req_ready); end
    rr_exp = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL backpressure_hold%0d: got %b, expected 00", c, bus.req_ready); end
    end
    set_req(0, 1'b0, 32'd0, 32'd0, 32'd0);
    bus.rsp_ready = 2'b11;
    repeat (5) tick();
  endtask

  task automatic test_grant_pop();
    logic [1:0] exp;
    logic       exp_rv;
    bus.rsp_ready = 2'b11;
    for (int c = 0; c < 9; c++) begin
      set_req(1, 1'b1, $urandom, $urandom, $urandom);
      #1;
      exp    = (c % 3 == 2) ? 2'b00 : 2'b10;
      exp_rv = (c >= 2) && ((c - 2) % 3 != 2);
      n_checks++;
      if ({bus.req_ready, bus.rsp_valid[1]} !== {exp, exp_rv}) begin
        n_fail++; $display("FAIL grant_pop_cycle%0d: got ready=%b rsp_valid1=%b, expected %b/%b", c, bus.req_ready, bus.rsp_valid[1], exp, exp_rv);
      end
      if (exp[1]) rr_exp = 0;
      tick();
    end
    set_req(1, 1'b0, 32'd0, 32'd0, 32'd0);
    repeat (4) tick();
  endtask

  task automatic test_flush();
    bus.rsp_ready = 2'b11;
    set_req(0, 1'b1, $urandom, $urandom, $urandom);
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL flush_grant: got %b, expected 01", bus.req_ready); end
    rr_exp = 1;
    tick();
    set_req(0, 1'b1, $urandom, $urandom, $urandom);
    bus.flush_req = 1'b1;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.flush_done} !== 3'b000) begin
      n_fail++; $display("FAIL flush_t1: got ready=%b done=%b, expected 00/0", bus.req_ready, bus.flush_done);
    end
    tick();
    n_checks++;
    if ({bus.req_ready, bus.flush_done, bus.rsp_valid[0]} !== 4'b0011) begin
      n_fail++; $display("FAIL flush_t2: got ready=%b done=%b rsp_valid0=%b, expected 00/1/1", bus.req_ready, bus.flush_done, bus.rsp_valid[0]);
    end
    tick();
    n_checks++;
    if ({bus.req_ready, bus.flush_done} !== 3'b000) begin
      n_fail++; $display("FAIL flush_t3: got ready=%b done=%b, expected 00/0", bus.req_ready, bus.flush_done);
    end
    tick();
    n_checks++;
    if ({bus.req_ready, bus.flush_done} !== 3'b001) begin
      n_fail++; $display("FAIL flush_t4_repulse: got ready=%b done=%b, expected 00/1", bus.req_ready, bus.flush_done);
    end
    tick();
    bus.flush_req = 1'b0;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.flush_done} !== 3'b010) begin
      n_fail++; $display("FAIL flush_resume: got ready=%b done=%b, expected 01/0", bus.req_ready, bus.flush_done);
    end
    rr_exp = 1;
    tick();
    set_req(0, 1'b0, 32'd0, 32'd0, 32'd0);
    repeat (4) tick();
  endtask

  task automatic test_reset_inflight();
    bus.rsp_ready = 2'b11;
    set_req(0, 1'b1, $urandom, $urandom, $urandom);
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_inflight_grant: got %b, expected 01", bus.req_ready); end
    tick();
    set_req(0, 1'b0, 32'd0, 32'd0, 32'd0);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.rsp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL rst_inflight_clear: got busy=%b rsp_valid=%b, expected 0", bus.busy, bus.rsp_valid);
    end
    tick();
    tick();
    reset  = 1'b0;
    rr_exp = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if ({bus.busy, bus.rsp_valid} !== 3'b000) begin
        n_fail++; $display("FAIL rst_inflight_late%0d: got busy=%b rsp_valid=%b, expected 0", c, bus.busy, bus.rsp_valid);
      end
    end
    bus.rsp_ready = 2'b00;
    for (int c = 0; c < 5; c++) begin
      set_req(0, 1'b1, $urandom, $urandom, $urandom);
      #1;
      n_checks++;
      if (bus.req_ready !== ((c < 2) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL rst_inflight_credit%0d: got %b, expected %b", c, bus.req_ready, (c < 2) ? 2'b01 : 2'b00);
      end
      tick();
    end
    set_req(0, 1'b0, 32'd0, 32'd0, 32'd0);
    bus.rsp_ready = 2'b11;
    repeat (5) tick();
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_instr = 64'd0;
    bus.req_rs1   = 64'd0;
    bus.req_rs2   = 64'd0;
    bus.req_bs    = 16'd0;
    bus.rsp_ready = 2'b00;
    bus.flush_req = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_grant_pop();
    test_flush();
    test_reset_inflight();
    for (int i = 0; i < NUM_REQ; i++) begin
      n_checks++;
      if (sb_q[i].size() != 0) begin
        n_fail++; $display("FAIL scoreboard_drain%0d: got %0d pending, expected 0", i, sb_q[i].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
